// File: rtl/fma16_issue.sv
// Issue buffer for the combinational fma16 datapath: a request FIFO whose head
// drives fma16, a registered result stage with sequence tags, and sticky flags.
module fma16_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  input  logic        in_mul,
  input  logic        in_add,
  input  logic        in_negr,
  input  logic        in_negz,
  input  logic [1:0]  in_rm,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic        fma_mul,
  output logic        fma_add,
  output logic        fma_negr,
  output logic        fma_negz,
  output logic [1:0]  fma_rm,
  input  logic [15:0] fma_result,
  input  logic [3:0]  fma_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic [2:0]  out_tag,
  output logic [3:0]  flags_sticky,
  input  logic        flags_clr,
  output logic [3:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 57;
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [3:0]    r_count;
  logic [2:0]    r_tag;
  logic          r_outValid;
  logic [15:0]   r_outResult;
  logic [3:0]    r_outFlags;
  logic [2:0]    r_outTag;
  logic [3:0]    r_sticky;

  logic          w_notEmpty;
  logic          w_push;
  logic          w_load;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;
  logic [2:0]    w_headTag;

  assign w_notEmpty = (r_count != 4'd0);
  assign in_ready   = (r_count < 4'(DEPTH));
  assign w_push     = in_valid & in_ready;
  assign w_load     = w_notEmpty & (~r_outValid | out_ready);

  assign w_entry = {r_tag, in_rm, in_mul, in_add, in_negr, in_negz, in_x, in_y, in_z};

  // An empty queue presents all-zero operands so fma16 never sees a stale entry.
  assign w_head = w_notEmpty ? r_mem[r_rdPtr] : '0;
  assign {w_headTag, fma_rm, fma_mul, fma_add, fma_negr, fma_negz,
          fma_x, fma_y, fma_z} = w_head;

  assign out_valid    = r_outValid;
  assign out_result   = r_outResult;
  assign out_flags    = r_outFlags;
  assign out_tag      = r_outTag;
  assign flags_sticky = r_sticky;
  assign count        = r_count;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wrPtr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= 4'd0;
      r_tag       <= 3'd0;
      r_outValid  <= 1'b0;
      r_outResult <= 16'd0;
      r_outFlags  <= 4'd0;
      r_outTag    <= 3'd0;
      r_sticky    <= 4'd0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
        r_tag   <= r_tag + 3'd1;
      end
      if (w_load) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end

      if (w_push && !w_load) begin
        r_count <= r_count + 4'd1;
      end else if (!w_push && w_load) begin
        r_count <= r_count - 4'd1;
      end

      // Without a load, out_ready can only be consumed when the queue is empty.
      if (w_load) begin
        r_outValid  <= 1'b1;
        r_outResult <= fma_result;
        r_outFlags  <= fma_flags;
        r_outTag    <= w_headTag;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end

      r_sticky <= (flags_clr ? 4'd0 : r_sticky) | (w_load ? fma_flags : 4'd0);
    end
  end

endmodule

// File: tb/tb_fma16_issue.sv
// Self-checking bench for fma16_issue with a behavioural fma16 stand-in and a
// queue scoreboard that predicts every result at push time.
module tb_fma16_issue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negr;
    logic        negz;
    logic [1:0]  rm;
  } req_t;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  flags;
    logic [2:0]  tag;
  } exp_t;

  localparam req_t IDLE = '0;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x, in_y, in_z;
  logic        in_mul, in_add, in_negr, in_negz;
  logic [1:0]  in_rm;
  logic [15:0] fma_x, fma_y, fma_z;
  logic        fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]  fma_rm;
  logic [15:0] fma_result;
  logic [3:0]  fma_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  out_tag;
  logic [3:0]  flags_sticky;
  logic        flags_clr;
  logic [3:0]  count;

  exp_t     expQ[$];
  int       errors = 0;
  int       checks = 0;
  logic [2:0] tbTag = 3'd0;

  always #5 clk = ~clk;

  // Stand-in for fma16: exact for 1.0*1.0 and 1.0+1.0, otherwise a scrambling
  // function whose flags come from z[3:0] so tests can choose the flags.
  function automatic logic [19:0] fmaModel(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic mul,
                                           input logic add, input logic negr,
                                           input logic negz, input logic [1:0] rm);
    if (mul && !add && !negr && !negz && y == 16'h3C00 && z == 16'h0000)
      return {x, 4'b0000};
    if (!mul && add && !negr && !negz && x == 16'h3C00 && z == 16'h3C00)
      return {16'h4000, 4'b0000};
    return {x ^ {y[14:0], y[15]} ^ ~z ^ {12'h000, mul, add, negr, negz} ^ {rm, 14'h0000},
            z[3:0]};
  endfunction

  assign {fma_result, fma_flags} = fmaModel(fma_x, fma_y, fma_z, fma_mul, fma_add,
                                            fma_negr, fma_negz, fma_rm);

  fma16_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .in_mul(in_mul), .in_add(in_add), .in_negr(in_negr), .in_negz(in_negz),
    .in_rm(in_rm),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
    .fma_rm(fma_rm),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr),
    .count(count)
  );

  function automatic req_t randReq();
    req_t r;
    r.x    = 16'($urandom);
    r.y    = 16'($urandom);
    r.z    = 16'($urandom);
    r.mul  = 1'($urandom);
    r.add  = 1'($urandom);
    r.negr = 1'($urandom);
    r.negz = 1'($urandom);
    r.rm   = 2'($urandom);
    return r;
  endfunction

  // Drives one cycle of inputs, then reports whether a push and a result
  // handshake will happen at the coming edge; pushes predictions on the queue.
  task automatic applyStimulus(input logic v, input req_t r, input logic ordy,
                               input logic clr, output logic pushed,
                               output logic popped, output exp_t got);
    logic [19:0] m;
    @(negedge clk);
    in_valid  = v;
    in_x      = r.x;
    in_y      = r.y;
    in_z      = r.z;
    in_mul    = r.mul;
    in_add    = r.add;
    in_negr   = r.negr;
    in_negz   = r.negz;
    in_rm     = r.rm;
    out_ready = ordy;
    flags_clr = clr;
    #1;
    pushed = in_valid && in_ready;
    popped = out_valid && out_ready;
    got    = {out_result, out_flags, out_tag};
    if (pushed) begin
      m = fmaModel(r.x, r.y, r.z, r.mul, r.add, r.negr, r.negz, r.rm);
      expQ.push_back({m[19:4], m[3:0], tbTag});
      tbTag = tbTag + 3'd1;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    {in_valid, in_x, in_y, in_z, in_mul, in_add, in_negr, in_negz, in_rm} = '0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    tbTag = 3'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_x = 16'h1111; in_y = 16'h2222; in_z = 16'h3333;
    in_mul = 1'b1; in_add = 1'b1; in_negr = 1'b0; in_negz = 1'b0; in_rm = 2'd1;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({out_result, out_flags, out_tag} !== 23'd0)
      begin errors++; $display("[TB] FAIL reset_out_regs: got %h expected 0", {out_result, out_flags, out_tag}); end
    checks++;
    if (flags_sticky !== 4'd0) begin errors++; $display("[TB] FAIL reset_sticky: got %b expected 0000", flags_sticky); end
    checks++;
    if ({fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_rm} !== 54'd0)
      begin errors++; $display("[TB] FAIL reset_fma_drive: got %h expected 0",
                              {fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_rm}); end
    in_valid = 1'b0;
    expQ.delete();
    tbTag = 3'd0;
  endtask

  task automatic test_fmul();
    req_t r;
    logic pushed, popped;
    exp_t got, e;
    applyReset();
    r = IDLE;
    r.x = 16'h3C00; r.y = 16'h3C00; r.mul = 1'b1;
    applyStimulus(1'b1, r, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if (pushed !== 1'b1) begin errors++; $display("[TB] FAIL fmul_accept: got %b expected 1", pushed); end
    checks++;
    if (fma_x !== 16'h0000) begin errors++; $display("[TB] FAIL fmul_no_bypass: got %h expected 0000", fma_x); end
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if ({count, out_valid} !== {4'd1, 1'b0})
      begin errors++; $display("[TB] FAIL fmul_queued: got count=%0d valid=%b expected count=1 valid=0", count, out_valid); end
    checks++;
    if ({fma_x, fma_y, fma_z, fma_mul, fma_add} !== {16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b0})
      begin errors++; $display("[TB] FAIL fmul_head_drive: got %h %h %h %b%b expected 3c00 3c00 0000 10",
                              fma_x, fma_y, fma_z, fma_mul, fma_add); end
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if (popped !== 1'b1) begin errors++; $display("[TB] FAIL fmul_latency: got valid=%b expected 1", popped); end
    checks++;
    if (got !== {16'h3C00, 4'h0, 3'd0})
      begin errors++; $display("[TB] FAIL fmul_result: got %h expected %h", got, {16'h3C00, 4'h0, 3'd0}); end
    if (popped) begin
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL fmul_sb: got %h expected none", got); end
      else begin
        e = expQ.pop_front();
        if (got !== e) begin errors++; $display("[TB] FAIL fmul_sb: got %h expected %h", got, e); end
      end
    end
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if ({out_valid, out_result, count} !== {1'b0, 16'h3C00, 4'd0})
      begin errors++; $display("[TB] FAIL fmul_drain_hold: got valid=%b res=%h count=%0d expected 0 3c00 0",
                              out_valid, out_result, count); end
  endtask

  task automatic test_fadd();
    req_t r;
    logic pushed, popped;
    exp_t got, e;
    r = IDLE;
    r.x = 16'h3C00; r.z = 16'h3C00; r.add = 1'b1;
    applyStimulus(1'b1, r, 1'b1, 1'b0, pushed, popped, got);
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if (popped !== 1'b0) begin errors++; $display("[TB] FAIL fadd_early: got valid=%b expected 0", popped); end
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if (popped !== 1'b1 || got !== {16'h4000, 4'h0, 3'd1})
      begin errors++; $display("[TB] FAIL fadd_result: got valid=%b %h expected 1 %h", popped, got, {16'h4000, 4'h0, 3'd1}); end
    if (popped) begin
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL fadd_sb: got %h expected none", got); end
      else begin
        e = expQ.pop_front();
        if (got !== e) begin errors++; $display("[TB] FAIL fadd_sb: got %h expected %h", got, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    req_t r6;
    logic pushed, popped, sixthIn;
    exp_t got, e, held;
    int nPushed, nPop;
    applyReset();
    nPushed = 0;
    for (int cyc = 0; cyc < 20 && nPushed < 5; cyc++) begin
      applyStimulus(1'b1, randReq(), 1'b0, 1'b0, pushed, popped, got);
      if (pushed) nPushed++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({count, in_ready, out_valid, out_tag} !== {4'd4, 1'b0, 1'b1, 3'd0})
      begin errors++; $display("[TB] FAIL bp_full: got count=%0d rdy=%b valid=%b tag=%0d expected 4 0 1 0",
                              count, in_ready, out_valid, out_tag); end
    held = {out_result, out_flags, out_tag};
    r6 = randReq();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, r6, 1'b0, 1'b0, pushed, popped, got);
      checks++;
      if (pushed !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_push: got %b expected 0", pushed); end
      checks++;
      if (got !== held) begin errors++; $display("[TB] FAIL bp_stable: got %h expected %h", got, held); end
    end
    nPop = 0;
    sixthIn = 1'b0;
    for (int cyc = 0; cyc < 30 && nPop < 6; cyc++) begin
      applyStimulus(!sixthIn, r6, 1'b1, 1'b0, pushed, popped, got);
      if (pushed) sixthIn = 1'b1;
      if (popped) begin
        checks++;
        if (got.tag !== 3'(nPop)) begin errors++; $display("[TB] FAIL bp_tag_order: got %0d expected %0d", got.tag, nPop); end
        checks++;
        if (expQ.size() == 0) begin errors++; $display("[TB] FAIL bp_sb: got %h expected none", got); end
        else begin
          e = expQ.pop_front();
          if (got !== e) begin errors++; $display("[TB] FAIL bp_sb: got %h expected %h", got, e); end
        end
        nPop++;
      end
    end
    checks++;
    if (nPop != 6) begin errors++; $display("[TB] FAIL bp_drain_timeout: got %0d results expected 6", nPop); end
  endtask

  task automatic test_tag_wrap();
    logic pushed, popped;
    exp_t got, e;
    int nPushed, nPop, gaps;
    applyReset();
    nPushed = 0; nPop = 0; gaps = 0;
    for (int cyc = 0; cyc < 60 && nPop < 10; cyc++) begin
      applyStimulus(nPushed < 10, randReq(), 1'b1, 1'b0, pushed, popped, got);
      if (pushed) nPushed++;
      if (popped) begin
        checks++;
        if (got.tag !== 3'(nPop % 8)) begin errors++; $display("[TB] FAIL wrap_tag: got %0d expected %0d", got.tag, nPop % 8); end
        checks++;
        if (expQ.size() == 0) begin errors++; $display("[TB] FAIL wrap_sb: got %h expected none", got); end
        else begin
          e = expQ.pop_front();
          if (got !== e) begin errors++; $display("[TB] FAIL wrap_sb: got %h expected %h", got, e); end
        end
        nPop++;
      end else if (nPop > 0 && nPop < 10) begin
        gaps++;
      end
    end
    checks++;
    if (nPop != 10) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d results expected 10", nPop); end
    checks++;
    if (gaps != 0) begin errors++; $display("[TB] FAIL wrap_throughput: got %0d bubbles expected 0", gaps); end
  endtask

  task automatic test_sticky();
    req_t r;
    logic pushed, popped;
    exp_t got, e;
    applyReset();
    r = IDLE;
    r.x = 16'h1234; r.y = 16'h5678; r.z = 16'h0001; r.mul = 1'b1; r.add = 1'b1;
    applyStimulus(1'b1, r, 1'b1, 1'b0, pushed, popped, got);
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if (flags_sticky !== 4'b0001) begin errors++; $display("[TB] FAIL sticky_set: got %b expected 0001", flags_sticky); end
    if (popped) begin
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL sticky_sb: got %h expected none", got); end
      else begin
        e = expQ.pop_front();
        if (got !== e) begin errors++; $display("[TB] FAIL sticky_sb: got %h expected %h", got, e); end
      end
    end
    r.z = 16'h0004;
    applyStimulus(1'b1, r, 1'b1, 1'b0, pushed, popped, got);
    applyStimulus(1'b0, IDLE, 1'b1, 1'b1, pushed, popped, got);
    applyStimulus(1'b0, IDLE, 1'b1, 1'b1, pushed, popped, got);
    checks++;
    if (flags_sticky !== 4'b0100) begin errors++; $display("[TB] FAIL sticky_clr_load: got %b expected 0100", flags_sticky); end
    checks++;
    if (popped !== 1'b1 || got.flags !== 4'b0100)
      begin errors++; $display("[TB] FAIL sticky_out_flags: got valid=%b flags=%b expected 1 0100", popped, got.flags); end
    if (popped) void'(expQ.pop_front());
    applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
    checks++;
    if (flags_sticky !== 4'b0000) begin errors++; $display("[TB] FAIL sticky_clr: got %b expected 0000", flags_sticky); end
  endtask

  task automatic test_mid_reset();
    req_t r;
    logic pushed, popped;
    exp_t got, e;
    int nPushed, nPop;
    applyReset();
    nPushed = 0;
    for (int cyc = 0; cyc < 20 && nPushed < 4; cyc++) begin
      r = randReq();
      r.z[3:0] = 4'h2;
      applyStimulus(1'b1, r, 1'b0, 1'b0, pushed, popped, got);
      if (pushed) nPushed++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({count, out_valid, flags_sticky} !== {4'd3, 1'b1, 4'b0010})
      begin errors++; $display("[TB] FAIL mid_pre: got count=%0d valid=%b sticky=%b expected 3 1 0010",
                              count, out_valid, flags_sticky); end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    flags_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if ({count, out_valid, in_ready, flags_sticky} !== {4'd0, 1'b0, 1'b1, 4'b0000})
      begin errors++; $display("[TB] FAIL mid_reset_state: got count=%0d valid=%b rdy=%b sticky=%b expected 0 0 1 0000",
                              count, out_valid, in_ready, flags_sticky); end
    expQ.delete();
    tbTag = 3'd0;
    nPop = 0;
    applyStimulus(1'b1, randReq(), 1'b1, 1'b0, pushed, popped, got);
    for (int cyc = 0; cyc < 10 && nPop < 1; cyc++) begin
      applyStimulus(1'b0, IDLE, 1'b1, 1'b0, pushed, popped, got);
      if (popped) begin
        checks++;
        if (got.tag !== 3'd0) begin errors++; $display("[TB] FAIL mid_tag: got %0d expected 0", got.tag); end
        checks++;
        if (expQ.size() == 0) begin errors++; $display("[TB] FAIL mid_sb: got %h expected none", got); end
        else begin
          e = expQ.pop_front();
          if (got !== e) begin errors++; $display("[TB] FAIL mid_sb: got %h expected %h", got, e); end
        end
        nPop++;
      end
    end
    checks++;
    if (nPop != 1) begin errors++; $display("[TB] FAIL mid_timeout: got %0d results expected 1", nPop); end
  endtask

  initial begin
    reset = 1'b0;
    {in_valid, in_x, in_y, in_z, in_mul, in_add, in_negr, in_negz, in_rm} = '0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    test_reset();
    test_fmul();
    test_fadd();
    test_backpressure();
    test_tag_wrap();
    test_sticky();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fma16_issue.md
FMA16_ISSUE -- requirements
Module: fma16_issue

Purpose: operation buffer for the combinational fma16 datapath. Queues requests, drives fma16 operand/control inputs from the queue head, captures result and flags into an output register, and accumulates sticky flags.

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of request-queue entries (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  queue can accept a request.
REQ-006 in_x, in_y, in_z  input  16 each  half-precision operands.
REQ-007 in_mul, in_add, in_negr, in_negz  input  1 each  operation controls, same encoding as fma16.
REQ-008 in_rm  input  2  rounding mode.
REQ-009 fma_x, fma_y, fma_z  output  16 each  operands to fma16.
REQ-010 fma_mul, fma_add, fma_negr, fma_negz  output  1 each  controls to fma16.
REQ-011 fma_rm  output  2  rounding mode to fma16.
REQ-012 fma_result  input  16  fma16 result, combinational from the fma_* outputs.
REQ-013 fma_flags  input  4  fma16 flags {NV,OF,UF,NX}.
REQ-014 out_valid  output  1  output register holds a result.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_result  output  16  captured result.
REQ-017 out_flags  output  4  captured flags.
REQ-018 out_tag  output  3  sequence tag of the captured request.
REQ-019 flags_sticky  output  4  OR of all captured flags since reset or clear.
REQ-020 flags_clr  input  1  clear sticky flags.
REQ-021 count  output  4  current queue occupancy, 0..DEPTH.

Function
REQ-022 Queue: circular FIFO with DEPTH entries; each entry holds x, y, z, the four controls, rm, and a 3-bit tag.
REQ-023 in_ready SHALL be 1 exactly when count < DEPTH; a pop in the same cycle SHALL NOT raise in_ready (no full-queue passthrough).
REQ-024 Push: when in_valid and in_ready are both 1 at an edge, the request is written at the write pointer.
REQ-025 Tag: a 3-bit counter, 0 after reset, is written with each push and then increments; it wraps 7 -> 0.
REQ-026 Head drive: when count > 0, fma_* SHALL equal the head entry combinationally; when count = 0, all fma_* outputs SHALL be 0.
REQ-027 Load condition: load = (count > 0) and (out_valid = 0 or out_ready = 1).
REQ-028 On load: out_result <= fma_result; out_flags <= fma_flags; out_tag <= head tag; out_valid <= 1; the head entry is popped.
REQ-029 When out_valid = 1, out_ready = 1, and count = 0, out_valid SHALL go to 0 at the edge; out_result, out_flags and out_tag hold their values.
REQ-030 When out_valid = 1 and out_ready = 0, out_result, out_flags and out_tag SHALL be stable.
REQ-031 Latency: a request pushed at edge k into an empty queue with an idle output SHALL be loaded at edge k+1, so out_valid = 1 from edge k+1.
REQ-032 Throughput: with out_ready held at 1, one result is produced per cycle.
REQ-033 A push into an empty queue SHALL NOT be visible at the head in the same cycle (no bypass).
REQ-034 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-035 Sticky flags: at each edge, flags_sticky <= (flags_clr ? 0 : flags_sticky) | (load ? fma_flags : 0); flags loaded in the same cycle as a clear are retained.
REQ-036 Ordering: results SHALL leave in push order, with consecutive tags modulo 8.

Reset
REQ-037 While reset = 1 at an edge, the block SHALL set count = 0, both pointers = 0, tag counter = 0, out_valid = 0, out_result = 0, out_flags = 0, out_tag = 0, and flags_sticky = 0.
REQ-038 Reset SHALL override any simultaneous push, load, or clear; queued and captured requests are discarded.
REQ-039 During reset, in_ready SHALL be derived from the reset count, so it is 1 after the reset edge.

Verification (bench instantiates fma16 on the fma_* ports)
REQ-040 Single fmul: push x=0x3C00, y=0x3C00, z=0, mul=1, add=0 at edge 0 -> out_valid=1 after edge 1, out_result=0x3C00, out_tag=0, out_flags=0.
REQ-041 Single fadd: push x=0x3C00, z=0x3C00, mul=0, add=1 -> out_result=0x4000, returned 2 edges after the push edge.
REQ-042 Backpressure/full: hold out_ready=0 and push 5 requests -> first loads the output register, next 4 fill the queue, count=4, in_ready=0; the 6th is stalled; releasing out_ready drains results in order with tags 0..4 and stable data while stalled.
REQ-043 Tag wrap: stream 10 requests with out_ready=1 -> tags 0..7, 0, 1; one result per cycle.
REQ-044 Sticky: stub fma_flags=4'b0001 on one load -> flags_sticky=0001; assert flags_clr in a cycle where a load carries 4'b0100 -> flags_sticky=0100.
REQ-045 Mid-operation reset: with count=3 and out_valid=1, assert reset for one edge -> count=0, out_valid=0, in_ready=1, flags_sticky=0; the next push gets tag 0.
